// File: rtl/ltc2600_pkg.sv
// Shared types and command encodings for the LTC2600 update scheduler.
package ltc2600_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam logic [3:0] CMD_WRITE_UPDATE_N = 4'b0011;
    localparam logic [3:0] CMD_WRITE_N        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE_N       = 4'b0001;
    localparam logic [3:0] ADDR_ALL           = 4'b1111;

    localparam int CNT_W = 16;

    // Round-robin successor of a channel index, wrapping at num_ch-1.
    function automatic logic [2:0] rr_next(input logic [2:0] ch, input int num_ch);
        return (int'(ch) == (num_ch - 1)) ? 3'd0 : (ch + 3'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set mask bit at or above
// ptr_i, wrapping from NUM_CH-1 back to 0.
module rr_pick
    import ltc2600_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [2:0]        ptr_i,
    output logic              valid_o,
    output logic [2:0]        idx_o
);

    logic [3:0] cand;
    logic [3:0] sum;
    logic       hit;
    logic       found;
    logic [2:0] pick;

    // Scan NUM_CH candidates starting at the pointer; the first hit latches.
    always_comb begin
        cand  = 4'd0;
        sum   = 4'd0;
        hit   = 1'b0;
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum   = {1'b0, ptr_i} + 4'(k);
            cand  = (sum >= 4'(NUM_CH)) ? (sum - 4'(NUM_CH)) : sum;
            hit   = mask_i[cand[2:0]] & ~found;
            pick  = hit ? cand[2:0] : pick;
            found = found | hit;
        end
    end

    assign valid_o = found;
    assign idx_o   = pick;

endmodule

// File: rtl/ltc2600_update_scheduler.sv
// Shadow setpoints for the LTC2600 DAC channels, pushed to the serial writer
// one dirty channel at a time. Define LTC2600_SCHED_TIMEOUT_EN for the WAIT watchdog.
module ltc2600_update_scheduler
    import ltc2600_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CH         = 8,
    parameter int ISSUE_CYCLES   = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_chan,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    output logic                  dac_send_new_cmd,
    output logic [3:0]            dac_command,
    output logic [3:0]            dac_address,
    output logic [DATA_WIDTH-1:0] dac_data,
    input  logic                  dac_write_complete,
    output logic                  busy,
    output logic [NUM_CH-1:0]     pending,
    output logic                  timeout_err
);

    sched_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [2:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_seen_q, done_seen_d;
    logic                  send_q, send_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [3:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_CH-1:0]     wr_mask;
    logic [NUM_CH-1:0]     clr_mask;
    logic [NUM_CH-1:0]     requeue_mask;
    logic                  wr_hit;
    logic                  pick_valid;
    logic [2:0]            pick_idx;

`ifdef LTC2600_SCHED_TIMEOUT_EN
    logic                  timeout_q, timeout_d;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .mask_i  (pending_q),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Host write decode; out-of-range channels are dropped.
    always_comb begin
        wr_mask = '0;
        wr_hit  = wr_en && (int'(wr_chan) < NUM_CH);
        if (wr_hit) begin
            wr_mask[wr_chan] = 1'b1;
        end else begin
            wr_mask = '0;
        end
        // Sets are applied after the selection clear, so a same-cycle write wins.
        pending_d = (pending_q & ~clr_mask) | requeue_mask | wr_mask | {NUM_CH{flush}};
    end

    // Transaction sequencer: selection, issue hold, completion wait, gap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_seen_d  = done_seen_q;
        send_d       = send_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rr_ptr_d     = rr_ptr_q;
        clr_mask     = '0;
        requeue_mask = '0;
`ifdef LTC2600_SCHED_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d            = ISSUE;
                    cnt_d              = '0;
                    done_seen_d        = 1'b0;
                    send_d             = 1'b1;
                    cmd_d              = CMD_WRITE_UPDATE_N;
                    addr_d             = {1'b0, pick_idx};
                    data_d             = shadow_q[pick_idx];
                    clr_mask[pick_idx] = 1'b1;
                    rr_ptr_d           = rr_next(pick_idx, NUM_CH);
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                done_seen_d = done_seen_q | dac_write_complete;
                if (cnt_q == CNT_W'(ISSUE_CYCLES - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    send_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT: begin
                if (dac_write_complete || done_seen_q) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    done_seen_d = 1'b0;
`ifdef LTC2600_SCHED_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d                   = GAP;
                    cnt_d                     = '0;
                    timeout_d                 = 1'b1;
                    requeue_mask[addr_q[2:0]] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                end else begin
                    state_d = WAIT;
                end
`endif
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                send_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, shadow and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= 3'd0;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
            send_q      <= 1'b0;
            cmd_q       <= 4'd0;
            addr_q      <= 4'd0;
            data_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            done_seen_q <= done_seen_d;
            send_q      <= send_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            if (wr_hit) begin
                shadow_q[wr_chan] <= wr_data;
            end
        end
    end

`ifdef LTC2600_SCHED_TIMEOUT_EN
    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign dac_send_new_cmd = send_q;
    assign dac_command      = cmd_q;
    assign dac_address      = addr_q;
    assign dac_data         = data_q;
    assign busy             = (state_q != IDLE);
    assign pending          = pending_q;

endmodule

// File: tb/tb_ltc2600_update_scheduler.sv
// Directed self-checking bench for ltc2600_update_scheduler; the host writer
// and the serial writer's completion pulse are driven by hand.
module tb_ltc2600_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_chan;
    logic [15:0] wr_data;
    logic        flush;
    logic        dac_send_new_cmd;
    logic [3:0]  dac_command;
    logic [3:0]  dac_address;
    logic [15:0] dac_data;
    logic        dac_write_complete;
    logic        busy;
    logic [7:0]  pending;
    logic        timeout_err;

    int n_checks = 0;
    int n_bad    = 0;

    ltc2600_update_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .wr_chan            (wr_chan),
        .wr_data            (wr_data),
        .flush              (flush),
        .dac_send_new_cmd   (dac_send_new_cmd),
        .dac_command        (dac_command),
        .dac_address        (dac_address),
        .dac_data           (dac_data),
        .dac_write_complete (dac_write_complete),
        .busy               (busy),
        .pending            (pending),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        wr_en              = 1'b0;
        wr_chan            = 3'd0;
        wr_data            = 16'h0000;
        flush              = 1'b0;
        dac_write_complete = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_ch(input logic [2:0] ch, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Waits for an issue, checks its fields and hold time; returns in WAIT.
    task automatic issue_check(input logic [2:0] ch, input logic [15:0] d);
        int n;
        int hi;
        logic stable;
        logic [3:0] c;
        logic [3:0] a;
        logic [15:0] dd;
        n = 0;
        while (dac_send_new_cmd !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_val("issue_seen", 32'(n < 64), 32'd1);
        c = dac_command;
        a = dac_address;
        dd = dac_data;
        hi = 0;
        stable = 1'b1;
        while (dac_send_new_cmd === 1'b1 && hi < 64) begin
            if (dac_command !== c || dac_address !== a || dac_data !== dd) stable = 1'b0;
            hi++;
            @(negedge clk);
        end
        if (dac_command !== c || dac_address !== a || dac_data !== dd) stable = 1'b0;
        check_val("cmd", 32'(c), 32'h3);
        check_val("addr", 32'(a), 32'({1'b0, ch}));
        check_val("data", 32'(dd), 32'(d));
        check_val("issue_len", 32'(hi), 32'd3);
        check_val("fields_stable", 32'(stable), 32'd1);
        check_val("busy_wait", 32'(busy), 32'd1);
    endtask

    // Single completion pulse, then measure the gap before IDLE.
    task automatic finish_txn();
        int g;
        dac_write_complete = 1'b1;
        @(negedge clk);
        dac_write_complete = 1'b0;
        g = 0;
        while (busy === 1'b1 && g < 64) begin
            g++;
            @(negedge clk);
        end
        check_val("gap_len", 32'(g), 32'd2);
    endtask

    logic [2:0]  flush_order [8] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [15:0] flush_data  [8] = '{16'h0000, 16'h0100, 16'h1234, 16'h0000,
                                     16'h0000, 16'h0000, 16'h5555, 16'h6666};

    initial begin
        int cnt;

        // Reset state and quiet idle.
        do_reset();
        check_val("rst_send", 32'(dac_send_new_cmd), 32'd0);
        check_val("rst_cmd", 32'(dac_command), 32'd0);
        check_val("rst_addr", 32'(dac_address), 32'd0);
        check_val("rst_data", 32'(dac_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_timeout", 32'(timeout_err), 32'd0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (dac_send_new_cmd === 1'b1 || busy === 1'b1) cnt++;
        end
        check_val("idle_quiet", 32'(cnt), 32'd0);

        // Single write: two-cycle latency, then one full transaction.
        write_ch(3'd3, 16'haaaa);
        check_val("lat_send_early", 32'(dac_send_new_cmd), 32'd0);
        check_val("lat_pending", 32'(pending), 32'h08);
        @(negedge clk);
        check_val("lat_send", 32'(dac_send_new_cmd), 32'd1);
        issue_check(3'd3, 16'haaaa);
        finish_txn();
        check_val("single_pending", 32'(pending), 32'd0);
        check_val("single_busy", 32'(busy), 32'd0);

        // Round-robin: ch0 in flight while 5,1,6 arrive; rr_ptr then sits at 1.
        do_reset();
        write_ch(3'd0, 16'h0100);
        write_ch(3'd5, 16'h5555);
        write_ch(3'd1, 16'h1234);
        write_ch(3'd6, 16'h6666);
        cnt = 0;
        while (dac_send_new_cmd === 1'b1 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check_val("rr_first_addr", 32'(dac_address), 32'h0);
        check_val("rr_first_data", 32'(dac_data), 32'h0100);
        check_val("rr_pending", 32'(pending), 32'h62);
        finish_txn();
        issue_check(3'd1, 16'h1234);
        finish_txn();
        issue_check(3'd5, 16'h5555);
        finish_txn();
        issue_check(3'd6, 16'h6666);
        finish_txn();
        check_val("rr_done_pending", 32'(pending), 32'd0);

        // Flush from rr_ptr=7 wraps through every channel.
        pulse_flush();
        check_val("flush_pending", 32'(pending), 32'hff);
        for (int i = 0; i < 8; i++) begin
            issue_check(flush_order[i], flush_data[i]);
            finish_txn();
        end
        check_val("flush_done", 32'(pending), 32'd0);

        // Rewrite during WAIT: in-flight data holds, new value goes next pass.
        write_ch(3'd2, 16'h1111);
        issue_check(3'd2, 16'h1111);
        check_val("rw_cleared", 32'(pending), 32'd0);
        write_ch(3'd2, 16'hffff);
        check_val("rw_repend", 32'(pending), 32'h04);
        check_val("rw_inflight", 32'(dac_data), 32'h1111);
        finish_txn();
        issue_check(3'd2, 16'hffff);
        check_val("rw_second_clear", 32'(pending), 32'd0);
        finish_txn();

        // Write on the selection edge: set wins, old value sent first.
        write_ch(3'd4, 16'h4444);
        write_ch(3'd4, 16'h4545);
        check_val("sw_pending", 32'(pending), 32'h10);
        issue_check(3'd4, 16'h4444);
        finish_txn();
        issue_check(3'd4, 16'h4545);
        finish_txn();
        check_val("sw_done", 32'(pending), 32'd0);

        // Completion during ISSUE is remembered: ISSUE 3 + WAIT 1 + GAP 2.
        write_ch(3'd0, 16'h0a0a);
        cnt = 0;
        while (dac_send_new_cmd !== 1'b1 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        dac_write_complete = 1'b1;
        @(negedge clk);
        dac_write_complete = 1'b0;
        cnt = 1;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            @(negedge clk);
        end
        check_val("early_done_busy", 32'(cnt), 32'd6);

        // Reset in ISSUE aborts and clears shadow state.
        do_reset();
        write_ch(3'd3, 16'h3333);
        write_ch(3'd6, 16'h6666);
        check_val("abort_pre_send", 32'(dac_send_new_cmd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_send", 32'(dac_send_new_cmd), 32'd0);
        check_val("abort_pending", 32'(pending), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_data", 32'(dac_data), 32'd0);
        check_val("abort_addr", 32'(dac_address), 32'd0);
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            issue_check(3'(i), 16'h0000);
            finish_txn();
        end

        // Withheld completion.
        do_reset();
        write_ch(3'd1, 16'h0bad);
        issue_check(3'd1, 16'h0bad);
`ifdef LTC2600_SCHED_TIMEOUT_EN
        repeat (4095) @(negedge clk);
        check_val("to_before", 32'(timeout_err), 32'd0);
        check_val("to_before_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("to_flag", 32'(timeout_err), 32'd1);
        check_val("to_requeue", 32'(pending), 32'h02);
        issue_check(3'd1, 16'h0bad);
        finish_txn();
        check_val("to_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        check_val("to_rst_clear", 32'(timeout_err), 32'd0);
`else
        repeat (4200) @(negedge clk);
        check_val("stall_busy", 32'(busy), 32'd1);
        check_val("stall_send", 32'(dac_send_new_cmd), 32'd0);
        check_val("stall_timeout", 32'(timeout_err), 32'd0);
        check_val("stall_pending", 32'(pending), 32'd0);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ltc2600_update_scheduler.md
Name: ltc2600_update_scheduler

Overview:
- Owns shadow setpoints for the 8 LTC2600 DAC channels.
- Sequences updates through the existing LTC2600 serial writer via its send_new_cmd / write_complete handshake.
- Host logic writes channel values at any time; the block marks them dirty and issues one "write and update n" command per dirty channel, round-robin, one transaction at a time.
- Sits between the control-register bank and the LTC2600 serial writer.

Parameters:
- DATA_WIDTH, 16, DAC code width; matches the writer's data port.
- NUM_CH, 8, number of DAC channels; must be ≤ 8.
- ISSUE_CYCLES, 3, clk cycles dac_send_new_cmd is held high per transaction; must be ≥ 1.
- GAP_CYCLES, 2, idle clk cycles after write_complete before the next issue; must be ≥ 1.
- TIMEOUT_CYCLES, 4096, WAIT watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe, one cycle.
- wr_chan  in  3  host channel index.
- wr_data  in  DATA_WIDTH  host setpoint.
- flush  in  1  one-cycle pulse; marks all channels dirty.
- dac_send_new_cmd  out  1  to writer send_new_cmd.
- dac_command  out  4  to writer command.
- dac_address  out  4  to writer address.
- dac_data  out  DATA_WIDTH  to writer data.
- dac_write_complete  in  1  writer completion pulse.
- busy  out  1  high when FSM is not in IDLE.
- pending  out  NUM_CH  dirty mask.
- timeout_err  out  1  sticky watchdog flag; tied 0 without the feature.

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - shadow regs = 0, pending = 0, rr_ptr = 0, state = IDLE.
  - All dac_* outputs = 0; busy = 0; timeout_err = 0.
  - Reset mid-transaction aborts immediately; dac_send_new_cmd drops at that same edge.
- Host write:
  - wr_en with wr_chan < NUM_CH: shadow[wr_chan] <= wr_data and pending[wr_chan] <= 1 at the next edge.
  - wr_chan ≥ NUM_CH is ignored.
- flush: pending <= all ones. Shadow values are unchanged.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If pending != 0, select the first set bit searching upward from rr_ptr, wrapping at NUM_CH-1 → 0.
  - Register the outputs: dac_command = 4'b0011, dac_address = {1'b0, chan}, dac_data = shadow[chan].
  - Clear pending[chan]; rr_ptr <= chan+1 mod NUM_CH.
  - Go to ISSUE. Latency from wr_en into an idle block to dac_send_new_cmd high: 2 cycles.
- ISSUE:
  - dac_send_new_cmd = 1 for exactly ISSUE_CYCLES cycles, then go to WAIT.
  - A dac_write_complete seen during ISSUE is latched and consumed on entry to WAIT.
- WAIT:
  - dac_send_new_cmd = 0.
  - On dac_write_complete (or the latched flag), go to GAP.
- GAP: count GAP_CYCLES, then go to IDLE.
- dac_command, dac_address and dac_data stay stable from entry to ISSUE until the next selection in IDLE.
- Simultaneous events:
  - Host write to the channel being selected in the same cycle: set wins, so pending stays 1. The old shadow value is sent now; the new value is sent on a later pass.
  - Host write during ISSUE/WAIT/GAP updates shadow and pending only; the in-flight dac_data does not change.
  - flush and wr_en in the same cycle: both apply.
- busy = (state != IDLE).

Optional Feature:
- Macro: LTC2600_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES without completion: set timeout_err (sticky until rst), re-set pending for the in-flight channel, go to GAP.
- Undefined:
  - No counter; WAIT blocks indefinitely.
  - timeout_err is constant 0.

Decomposition:
- Package ltc2600_pkg holds:
  - enum sched_state_t {IDLE, ISSUE, WAIT, GAP};
  - localparams CMD_WRITE_UPDATE_N = 4'b0011, CMD_WRITE_N = 4'b0000, CMD_UPDATE_N = 4'b0001, ADDR_ALL = 4'b1111.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs are the mask and pointer; outputs are a valid flag and the index.

Test Plan:
- Reset then idle, no writes → all outputs 0, busy 0, dac_send_new_cmd never asserts over 100 cycles.
- wr_en chan 3, data 16'haaaa → 2 cycles later dac_send_new_cmd high for 3 cycles with cmd 0011, addr 0011, data aaaa. Writer-model pulse of write_complete → busy drops after GAP; pending = 0.
- Writes to chans 5, 1, 6 in one burst with rr_ptr = 0 → issue order 1, 5, 6. Then flush → order 7, 0, 1, …, 6 (wrap from rr_ptr = 7).
- Write chan 2 = 16'h1111, then during WAIT write chan 2 = 16'hffff → first transaction sends 1111, second sends ffff, and pending[2] clears only after the second selection.
- rst asserted during ISSUE → dac_send_new_cmd 0 at the next edge, pending 0, shadow 0, state IDLE.
- (LTC2600_SCHED_TIMEOUT_EN) with write_complete withheld → at cycle 4096 in WAIT, timeout_err = 1 and the channel is re-issued. Without the macro → it stays in WAIT and timeout_err = 0.
